// File: rtl/dmem_responder.sv
// dmem_responder
// Data-memory responder for the cpu data bus. A request (CS high) is captured
// in IDLE, held for WAIT_CYCLES wait states, then committed against a
// word-organised synchronous RAM. Completion is signalled by a one-cycle
// Ready strobe. Err accompanies Ready for misaligned or out-of-window
// addresses.
//
// Optional feature macro: DMEM_BYTE_WRITE_EN
//   When it is defined, the BE port exists and writes update only the bytes
//   whose enable bit is set. When it is undefined, every write stores a full
//   word.
//
// Ports:
//   CLK            in   system clock, rising edge
//   Reset          in   synchronous active-high reset
//   ADDR           in   byte address
//   Data_BUS_WRITE in   write data
//   CS             in   request / chip select, held until Ready
//   WE             in   1 = write, 0 = read
//   BE             in   byte enables (only with DMEM_BYTE_WRITE_EN)
//   Data_BUS_READ  out  registered read data
//   Ready          out  one-cycle completion strobe
//   Err            out  error flag, valid while Ready is high
module dmem_responder #(
    parameter int          DEPTH_LOG2  = 10,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_2000,
    parameter int          WAIT_CYCLES = 2
) (
    input  logic        CLK,
    input  logic        Reset,
    input  logic [31:0] ADDR,
    input  logic [31:0] Data_BUS_WRITE,
    input  logic        CS,
    input  logic        WE,
`ifdef DMEM_BYTE_WRITE_EN
    input  logic [3:0]  BE,
`endif
    output logic [31:0] Data_BUS_READ,
    output logic        Ready,
    output logic        Err
);

    localparam int          DEPTH     = 1 << DEPTH_LOG2;
    localparam logic [32:0] MEM_BYTES = 33'd4 << DEPTH_LOG2;

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t                r_state;
    logic [3:0]            r_wcnt;
    logic [31:0]           r_addr;
    logic [31:0]           r_wdata;
    logic                  r_we;
    logic [31:0]           r_mem [0:DEPTH-1];
`ifdef DMEM_BYTE_WRITE_EN
    logic [3:0]            r_be;
    logic [3:0]            w_cBe;
`endif

    logic [31:0]           w_cAddr;
    logic [31:0]           w_cWdata;
    logic                  w_cWe;
    logic [31:0]           w_off;
    logic                  w_err;
    logic                  w_commit;
    logic [DEPTH_LOG2-1:0] w_idx;

    // With zero wait states the access commits on the capture edge, so the
    // request fields come straight from the bus while in IDLE and from the
    // latched copies otherwise.
    always_comb begin
        w_cAddr  = (r_state == IDLE) ? ADDR           : r_addr;
        w_cWdata = (r_state == IDLE) ? Data_BUS_WRITE : r_wdata;
        w_cWe    = (r_state == IDLE) ? WE             : r_we;
`ifdef DMEM_BYTE_WRITE_EN
        w_cBe    = (r_state == IDLE) ? BE             : r_be;
`endif
    end

    // The explicit lower-bound compare keeps addresses below the window from
    // wrapping into a valid offset; the 33-bit upper compare avoids overflow
    // of the window size.
    always_comb begin
        w_off    = w_cAddr - BASE_ADDR;
        w_err    = (w_cAddr[1:0] != 2'b00) || (w_cAddr < BASE_ADDR) ||
                   ({1'b0, w_off} >= MEM_BYTES);
        w_idx    = w_off[DEPTH_LOG2+1:2];
        w_commit = !Reset && CS &&
                   (((r_state == IDLE) && (WAIT_CYCLES == 0)) ||
                    ((r_state == WAIT) && (r_wcnt == 4'd0)));
    end

    // RAM write port. It is never reset; an erroneous access or a reset on
    // the commit edge suppresses the write.
    always_ff @(posedge CLK) begin
        if (w_commit && w_cWe && !w_err) begin
`ifdef DMEM_BYTE_WRITE_EN
            for (int i = 0; i < 4; i++) begin
                if (w_cBe[i]) begin
                    r_mem[w_idx][8*i +: 8] <= w_cWdata[8*i +: 8];
                end
            end
`else
            r_mem[w_idx] <= w_cWdata;
`endif
        end
    end

    // Control FSM with registered outputs. The commit block after the case
    // overrides the state-specific assignments on the commit edge.
    always_ff @(posedge CLK) begin
        if (Reset) begin
            r_state       <= IDLE;
            r_wcnt        <= 4'd0;
            r_addr        <= 32'h0;
            r_wdata       <= 32'h0;
            r_we          <= 1'b0;
`ifdef DMEM_BYTE_WRITE_EN
            r_be          <= 4'h0;
`endif
            Ready         <= 1'b0;
            Err           <= 1'b0;
            Data_BUS_READ <= 32'h0;
        end else begin
            case (r_state)
                IDLE: begin
                    Ready <= 1'b0;
                    Err   <= 1'b0;
                    if (CS) begin
                        r_addr  <= ADDR;
                        r_wdata <= Data_BUS_WRITE;
                        r_we    <= WE;
`ifdef DMEM_BYTE_WRITE_EN
                        r_be    <= BE;
`endif
                        if (WAIT_CYCLES != 0) begin
                            r_wcnt  <= 4'(WAIT_CYCLES - 1);
                            r_state <= WAIT;
                        end
                    end
                end
                WAIT: begin
                    if (!CS) begin
                        r_state <= IDLE;
                    end else if (r_wcnt != 4'd0) begin
                        r_wcnt <= r_wcnt - 4'd1;
                    end
                end
                RESP: begin
                    Ready   <= 1'b0;
                    Err     <= 1'b0;
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase

            if (w_commit) begin
                r_state <= RESP;
                Ready   <= 1'b1;
                Err     <= w_err;
                if (!w_cWe) begin
                    Data_BUS_READ <= w_err ? 32'h0 : r_mem[w_idx];
                end
            end
        end
    end

endmodule

// File: tb/tb_dmem_responder.sv
// Testbench for dmem_responder. Two instances share the bus: dut0 runs with
// two wait states, dut1 with none. Expected responses are queued as each
// request is issued and a per-instance monitor checks them on every Ready.
module tb_dmem_responder;

    typedef struct packed {
        logic [31:0] data;
        logic        err;
    } exp_t;

    logic        CLK = 1'b0;
    logic        Reset = 1'b1;
    logic [31:0] addr = 32'h0;
    logic [31:0] wdata = 32'h0;
    logic        we = 1'b0;
    logic [1:0]  cs = 2'b00;
    logic [1:0]  rdy;
    logic [1:0]  err;
    logic [31:0] rd0;
    logic [31:0] rd1;
`ifdef DMEM_BYTE_WRITE_EN
    logic [3:0]  be = 4'hF;
`endif

    exp_t q0[$];
    exp_t q1[$];
    exp_t e0;
    exp_t e1;
    logic prevRdy0 = 1'b0;
    logic prevRdy1 = 1'b0;
    int   total = 0;
    int   bad = 0;

    dmem_responder #(.DEPTH_LOG2(10), .BASE_ADDR(32'h2000), .WAIT_CYCLES(2)) dut0 (
        .CLK(CLK), .Reset(Reset), .ADDR(addr), .Data_BUS_WRITE(wdata),
        .CS(cs[0]), .WE(we),
`ifdef DMEM_BYTE_WRITE_EN
        .BE(be),
`endif
        .Data_BUS_READ(rd0), .Ready(rdy[0]), .Err(err[0])
    );

    dmem_responder #(.DEPTH_LOG2(10), .BASE_ADDR(32'h2000), .WAIT_CYCLES(0)) dut1 (
        .CLK(CLK), .Reset(Reset), .ADDR(addr), .Data_BUS_WRITE(wdata),
        .CS(cs[1]), .WE(we),
`ifdef DMEM_BYTE_WRITE_EN
        .BE(be),
`endif
        .Data_BUS_READ(rd1), .Ready(rdy[1]), .Err(err[1])
    );

    // Free-running clock, 10 time units per cycle.
    always #5 CLK = ~CLK;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("[TB] FAIL %s: got %h expected %h", name, act, want);
        end
    endtask

    // Issue one request on instance sel and wait (bounded) for its Ready.
    // The expected response is queued before CS rises.
    task automatic applyStimulus(input int sel, input logic [31:0] a, input logic [31:0] d,
                                 input logic w, input logic [31:0] expData, input logic expErr,
                                 input int expCycles, input bit holdCs);
        int   cycles;
        logic seen;
        exp_t e;
        e.data = expData;
        e.err  = expErr;
        if (sel == 0) q0.push_back(e);
        else          q1.push_back(e);
        addr    = a;
        wdata   = d;
        we      = w;
        cs[sel] = 1'b1;
        cycles  = 0;
        seen    = 1'b0;
        while (!seen && cycles < 32) begin
            @(negedge CLK);
            cycles++;
            seen = rdy[sel];
        end
        checkOutput($sformatf("latency dut%0d addr %h", sel, a), 32'(cycles), 32'(expCycles));
        if (!holdCs) begin
            cs[sel] = 1'b0;
            @(negedge CLK);
        end
    endtask

    // Monitor for dut0: every Ready must match a queued expectation and
    // must not last more than one cycle.
    always @(negedge CLK) begin
        if (rdy[0]) begin
            checkOutput("dut0 ready width", {31'b0, prevRdy0}, 32'h0);
            checkOutput("dut0 ready expected", 32'(q0.size() != 0), 32'h1);
            if (q0.size() != 0) begin
                e0 = q0.pop_front();
                checkOutput("dut0 data", rd0, e0.data);
                checkOutput("dut0 err", {31'b0, err[0]}, {31'b0, e0.err});
            end
        end
        prevRdy0 = rdy[0];
    end

    // Monitor for dut1, same rules as dut0.
    always @(negedge CLK) begin
        if (rdy[1]) begin
            checkOutput("dut1 ready width", {31'b0, prevRdy1}, 32'h0);
            checkOutput("dut1 ready expected", 32'(q1.size() != 0), 32'h1);
            if (q1.size() != 0) begin
                e1 = q1.pop_front();
                checkOutput("dut1 data", rd1, e1.data);
                checkOutput("dut1 err", {31'b0, err[1]}, {31'b0, e1.err});
            end
        end
        prevRdy1 = rdy[1];
    end

    // Hard time limit so the run always ends.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    // Directed stimulus.
    initial begin
        repeat (2) @(negedge CLK);
        Reset = 1'b0;
        checkOutput("reset rd0", rd0, 32'h0);
        checkOutput("reset ready", {30'b0, rdy}, 32'h0);
        checkOutput("reset err", {30'b0, err}, 32'h0);

        // Zero wait states: two writes, then back-to-back reads with CS held.
        applyStimulus(1, 32'h2000, 32'h01010101, 1'b1, 32'h0, 1'b0, 1, 1'b0);
        applyStimulus(1, 32'h2004, 32'h02020202, 1'b1, 32'h0, 1'b0, 1, 1'b0);
        applyStimulus(1, 32'h2000, 32'h0, 1'b0, 32'h01010101, 1'b0, 1, 1'b1);
        applyStimulus(1, 32'h2004, 32'h0, 1'b0, 32'h02020202, 1'b0, 2, 1'b0);

        // Two wait states: basic traffic and window boundaries.
        applyStimulus(0, 32'h2000, 32'hDEADBEEF, 1'b1, 32'h0, 1'b0, 3, 1'b0);
        applyStimulus(0, 32'h2000, 32'h0, 1'b0, 32'hDEADBEEF, 1'b0, 3, 1'b0);
        applyStimulus(0, 32'h2FFC, 32'hA5A5A5A5, 1'b1, 32'hDEADBEEF, 1'b0, 3, 1'b0);
        applyStimulus(0, 32'h2FFC, 32'h0, 1'b0, 32'hA5A5A5A5, 1'b0, 3, 1'b0);
        applyStimulus(0, 32'h2004, 32'h22222222, 1'b1, 32'hA5A5A5A5, 1'b0, 3, 1'b0);
        applyStimulus(0, 32'h2010, 32'h12345678, 1'b1, 32'hA5A5A5A5, 1'b0, 3, 1'b0);

        // Error responses: misaligned read, below window, above window.
        applyStimulus(0, 32'h2002, 32'h0, 1'b0, 32'h0, 1'b1, 3, 1'b0);
        applyStimulus(0, 32'h1FFC, 32'h0BADBAD0, 1'b1, 32'h0, 1'b1, 3, 1'b0);
        applyStimulus(0, 32'h3000, 32'h0BADBAD0, 1'b1, 32'h0, 1'b1, 3, 1'b0);
        // The rejected writes would alias onto the last and first words.
        applyStimulus(0, 32'h2FFC, 32'h0, 1'b0, 32'hA5A5A5A5, 1'b0, 3, 1'b0);
        applyStimulus(0, 32'h2000, 32'h0, 1'b0, 32'hDEADBEEF, 1'b0, 3, 1'b0);

        // Abort: CS dropped while waiting.
        addr  = 32'h2010;
        wdata = 32'hCAFEF00D;
        we    = 1'b1;
        cs[0] = 1'b1;
        @(negedge CLK);
        cs[0] = 1'b0;
        repeat (4) @(negedge CLK);
        applyStimulus(0, 32'h2010, 32'h0, 1'b0, 32'h12345678, 1'b0, 3, 1'b0);

        // Reset while a write is waiting.
        addr  = 32'h2004;
        wdata = 32'h11111111;
        we    = 1'b1;
        cs[0] = 1'b1;
        @(negedge CLK);
        Reset = 1'b1;
        cs[0] = 1'b0;
        @(negedge CLK);
        Reset = 1'b0;
        checkOutput("mid reset rd0", rd0, 32'h0);
        checkOutput("mid reset rd1", rd1, 32'h0);
        checkOutput("mid reset ready", {30'b0, rdy}, 32'h0);
        checkOutput("mid reset err", {30'b0, err}, 32'h0);
        repeat (4) @(negedge CLK);
        applyStimulus(0, 32'h2004, 32'h0, 1'b0, 32'h22222222, 1'b0, 3, 1'b0);

`ifdef DMEM_BYTE_WRITE_EN
        // Byte-enable writes.
        be = 4'hF;
        applyStimulus(0, 32'h2020, 32'hFFFFFFFF, 1'b1, 32'h22222222, 1'b0, 3, 1'b0);
        be = 4'b0101;
        applyStimulus(0, 32'h2020, 32'h00000000, 1'b1, 32'h22222222, 1'b0, 3, 1'b0);
        be = 4'b0000;
        applyStimulus(0, 32'h2020, 32'h12345678, 1'b1, 32'h22222222, 1'b0, 3, 1'b0);
        be = 4'b1010;
        applyStimulus(0, 32'h2020, 32'h0, 1'b0, 32'hFF00FF00, 1'b0, 3, 1'b0);
        be = 4'hF;
`endif

        repeat (4) @(negedge CLK);
        checkOutput("dut0 queue drained", 32'(q0.size()), 32'h0);
        checkOutput("dut1 queue drained", 32'(q1.size()), 32'h0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
